// File: rtl/root.sv
// Three-channel brushed DC motor controller: oversampled SPI register slave, shared
// 8-bit PWM, cycle-by-cycle current limiting and a host-activity watchdog.
module root (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output tri         miso,
    input  logic       tstn,
    input  logic       wdogdisn,
    input  logic       currentlimit0,
    input  logic       currentlimit1,
    input  logic       currentlimit2,
    input  logic [1:0] tach0,
    input  logic [1:0] tach1,
    input  logic [1:0] tach2,
    output logic       motorena,
    output logic [1:0] pwm0,
    output logic [1:0] pwm1,
    output logic [1:0] pwm2
);

    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [2:0] tach_sync_q [3];
    logic [2:0] tach_sync_d [3];
    logic [1:0] cl_sync_q [3];
    logic [1:0] cl_sync_d [3];
    logic       ss_armed_q, ss_armed_d;
    logic       miso_oe_q, miso_oe_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] duty_q [3];
    logic [7:0] duty_d [3];
    logic [7:0] tach_cnt_q [3];
    logic [7:0] tach_cnt_d [3];
    logic [2:0] dir_q, dir_d, brake_q, brake_d;
    logic [7:0] wdiv_q, wdiv_d;
    logic [2:0] chen_q, chen_d;
    logic       mena_q, mena_d, tripped_q, tripped_d;
    logic [5:0] presc_q, presc_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [2:0] cl_latch_q, cl_latch_d;
    logic [1:0] pwm_q [3];
    logic [1:0] pwm_d [3];
    logic       motorena_q, motorena_d;

    logic [2:0] cl_in, tach_in;
    logic       sclk_rise, ss_rise, frame_done, wr_en, wr_wdctl, wd_clr, tick, wrap;
    logic [7:0] wdata, rd_data;
    logic       unused_tach;

    assign cl_in       = {currentlimit2, currentlimit1, currentlimit0};
    assign tach_in     = {tach2[0], tach1[0], tach0[0]};
    assign unused_tach = ^{tach2[1], tach1[1], tach0[1]};
    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
    assign wdata       = {rx_q, mosi_sync_q[1]};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        ss_sync_d   = {ss_sync_q[1:0], ss};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        for (int ch = 0; ch < 3; ch++) begin
            tach_sync_d[ch] = {tach_sync_q[ch][1:0], tach_in[ch]};
            cl_sync_d[ch]   = {cl_sync_q[ch][0], cl_in[ch]};
            tach_cnt_d[ch]  = tach_cnt_q[ch] + {7'd0, tach_sync_q[ch][1] & ~tach_sync_q[ch][2]};
        end
        // MISO only drives once a genuine low on ss has been seen since reset
        ss_armed_d = ss_armed_q | ~ss_sync_q[1];
        miso_oe_d  = ss_sync_q[1] & ss_armed_q;
    end

    always_comb begin
        rd_data = '0;
        case (wdata[6:3])
            4'h0:    rd_data = duty_q[0];
            4'h1:    rd_data = tach_cnt_q[0];
            4'h2:    rd_data = {6'd0, brake_q[0], dir_q[0]};
            4'h3:    rd_data = {7'd0, cl_sync_q[0][1]};
            4'h4:    rd_data = duty_q[1];
            4'h5:    rd_data = tach_cnt_q[1];
            4'h6:    rd_data = {6'd0, brake_q[1], dir_q[1]};
            4'h7:    rd_data = {7'd0, cl_sync_q[1][1]};
            4'h8:    rd_data = duty_q[2];
            4'h9:    rd_data = tach_cnt_q[2];
            4'hA:    rd_data = {6'd0, brake_q[2], dir_q[2]};
            4'hB:    rd_data = {7'd0, cl_sync_q[2][1]};
            4'hD:    rd_data = {tstn, wdogdisn, 4'b0000, 2'b11};
            4'hE:    rd_data = wdiv_q;
            4'hF:    rd_data = {1'b0, tripped_q, 2'b00, mena_q, chen_q};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        frame_done = 1'b0;
        wr_en      = 1'b0;
        if (ss_rise) begin
            bit_cnt_d = '0;
            tx_d      = '0;
        end else if (ss_sync_q[1] && sclk_rise && bit_cnt_q != 5'd16) begin
            rx_d      = wdata[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
                rw_d   = wdata[7];
                addr_d = wdata[6:3];
                if (wdata[7]) tx_d = rd_data;
            end else if (bit_cnt_q == 5'd15) begin
                frame_done = 1'b1;
                wr_en      = ~rw_q;
            end else if (bit_cnt_q >= 5'd8) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        duty_d  = duty_q;
        dir_d   = dir_q;
        brake_d = brake_q;
        wdiv_d  = wdiv_q;
        if (wr_en) begin
            case (addr_q)
                4'h0:    duty_d[0] = wdata;
                4'h4:    duty_d[1] = wdata;
                4'h8:    duty_d[2] = wdata;
                4'h2:    {brake_d[0], dir_d[0]} = wdata[1:0];
                4'h6:    {brake_d[1], dir_d[1]} = wdata[1:0];
                4'hA:    {brake_d[2], dir_d[2]} = wdata[1:0];
                4'hE:    wdiv_d = wdata;
                default: ;
            endcase
        end
    end

    // Prescaler restarts on every count clear so the timeout lands in [WDIV*64, (WDIV+1)*64]
    assign wr_wdctl = wr_en && (addr_q == 4'hF);
    assign wd_clr   = wr_wdctl && wdata[7];
    assign tick     = (presc_q == 6'd0);

    always_comb begin
        presc_d   = (wd_clr || frame_done) ? 6'd63 : presc_q - 6'd1;
        wd_cnt_d  = wd_cnt_q;
        tripped_d = tripped_q;
        mena_d    = mena_q;
        chen_d    = chen_q;
        if (wr_wdctl) begin
            chen_d = wdata[2:0];
            mena_d = wdata[3];
        end
        if (!wdogdisn || wd_clr) begin
            wd_cnt_d  = '0;
            tripped_d = 1'b0;
        end else begin
            if (frame_done) wd_cnt_d = '0;
            else if (tick && !tripped_q && wd_cnt_q != 8'hFF) wd_cnt_d = wd_cnt_q + 8'd1;
            if (wdiv_q != 8'd0 && wd_cnt_q >= wdiv_q) begin
                tripped_d = 1'b1;
                mena_d    = 1'b0;
            end
        end
        motorena_d = mena_d & ~tripped_d;
    end

    assign wrap = (pcnt_q == 8'hFF);

    always_comb begin
        pcnt_d     = pcnt_q + 8'd1;
        cl_latch_d = cl_latch_q;
        for (int ch = 0; ch < 3; ch++) begin
            cl_latch_d[ch] = cl_sync_q[ch][1] | (cl_latch_q[ch] & ~wrap);
            pwm_d[ch]      = 2'b00;
            if (motorena_q && chen_q[ch] && !brake_q[ch] && !cl_latch_q[ch]) begin
                pwm_d[ch] = dir_q[ch] ? {pcnt_q < duty_q[ch], 1'b0} : {1'b0, pcnt_q < duty_q[ch]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // idle-high sclk and an assumed-selected ss so no false edge follows reset
            sclk_sync_q <= 3'b111;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= '0;
            ss_armed_q  <= 1'b0;
            miso_oe_q   <= 1'b0;
            bit_cnt_q   <= 5'd16;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                tach_sync_q[ch] <= '0;
                cl_sync_q[ch]   <= '0;
                duty_q[ch]      <= '0;
                tach_cnt_q[ch]  <= '0;
                pwm_q[ch]       <= '0;
            end
            dir_q      <= '0;
            brake_q    <= '0;
            wdiv_q     <= '0;
            chen_q     <= '0;
            mena_q     <= 1'b0;
            tripped_q  <= 1'b0;
            presc_q    <= '0;
            wd_cnt_q   <= '0;
            pcnt_q     <= '0;
            cl_latch_q <= '0;
            motorena_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_armed_q  <= ss_armed_d;
            miso_oe_q   <= miso_oe_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            for (int ch = 0; ch < 3; ch++) begin
                tach_sync_q[ch] <= tach_sync_d[ch];
                cl_sync_q[ch]   <= cl_sync_d[ch];
                duty_q[ch]      <= duty_d[ch];
                tach_cnt_q[ch]  <= tach_cnt_d[ch];
                pwm_q[ch]       <= pwm_d[ch];
            end
            dir_q      <= dir_d;
            brake_q    <= brake_d;
            wdiv_q     <= wdiv_d;
            chen_q     <= chen_d;
            mena_q     <= mena_d;
            tripped_q  <= tripped_d;
            presc_q    <= presc_d;
            wd_cnt_q   <= wd_cnt_d;
            pcnt_q     <= pcnt_d;
            cl_latch_q <= cl_latch_d;
            motorena_q <= motorena_d;
        end
    end

    assign miso     = miso_oe_q ? tx_q[7] : 1'bz;
    assign motorena = motorena_q;
    assign pwm0     = pwm_q[0];
    assign pwm1     = pwm_q[1];
    assign pwm2     = pwm_q[2];

endmodule

// File: tb/tb_root.sv
// Bench for the motor controller core: SPI host model, register/watchdog model and
// PWM duty measurement over full 256-clock periods.
module tb_root;

    logic       clk = 1'b0;
    logic       reset, sclk, ss, mosi, tstn, wdogdisn;
    logic       cl0, cl1, cl2;
    logic [1:0] tach0, tach1, tach2;
    tri         miso;
    logic       motorena;
    logic [1:0] pwm0, pwm1, pwm2;

    int n_cmp = 0;
    int n_mis = 0;

    pullup (miso);

    always #5 clk = ~clk;

    root dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tstn(tstn), .wdogdisn(wdogdisn),
        .currentlimit0(cl0), .currentlimit1(cl1), .currentlimit2(cl2),
        .tach0(tach0), .tach1(tach1), .tach2(tach2),
        .motorena(motorena), .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2)
    );

    // reference model of the register map
    logic [7:0] m_duty [3];
    logic [1:0] m_cfg [3];
    logic [7:0] m_tach [3];
    logic [7:0] m_wdiv;
    logic [2:0] m_en;
    logic       m_mena, m_trip;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_duty[i] = 0; m_cfg[i] = 0; m_tach[i] = 0;
        end
        m_wdiv = 0; m_en = 0; m_mena = 0; m_trip = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        logic [2:0] cl;
        int ch;
        cl = {cl2, cl1, cl0};
        ch = int'(a) / 4;
        if (a < 4'hC) begin
            case (a % 4)
                0: return m_duty[ch];
                1: return m_tach[ch];
                2: return {6'd0, m_cfg[ch]};
                default: return {7'd0, cl[ch]};
            endcase
        end
        if (a == 4'hD) return {tstn, wdogdisn, 6'b000011};
        if (a == 4'hE) return m_wdiv;
        if (a == 4'hF) return {1'b0, m_trip, 2'b00, m_mena, m_en};
        return 8'h00;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        if (a < 4'hC && a % 4 == 0) m_duty[int'(a) / 4] = d;
        if (a < 4'hC && a % 4 == 2) m_cfg[int'(a) / 4] = d[1:0];
        if (a == 4'hE) m_wdiv = d;
        if (a == 4'hF) begin
            if (d[7]) m_trip = 0;
            m_en = d[2:0];
            m_mena = d[3];
        end
    endtask

    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                             output logic [7:0] rd);
        logic [15:0] sh;
        sh = {b0, b1};
        rd = 0;
        @(negedge clk);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = sh[15-i];
            repeat (4) @(negedge clk);
            if (i >= 8) rd = {rd[6:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        spi_frame({1'b0, a, 3'b000}, d, 16, dummy);
        model_write(a, d);
    endtask

    task automatic spi_rd_chk(input string tag, input logic [3:0] a);
        logic [7:0] rd;
        spi_frame({1'b1, a, 3'b000}, 8'h00, 16, rd);
        check_val($sformatf("%s@%0h", tag, a), rd, model_read(a));
    endtask

    task automatic measure(input int ch, output int hi_f, output int hi_r);
        logic [1:0] p;
        hi_f = 0; hi_r = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            p = (ch == 0) ? pwm0 : (ch == 1) ? pwm1 : pwm2;
            hi_f += int'(p[0]);
            hi_r += int'(p[1]);
        end
    endtask

    task automatic check_pwm(input string tag, input int ch);
        int hf, hr, expect_hi;
        measure(ch, hf, hr);
        expect_hi = (m_mena && !m_trip && m_en[ch] && !m_cfg[ch][1]) ? int'(m_duty[ch]) : 0;
        check_val($sformatf("%s_fwd ch%0d duty%0h cfg%0d", tag, ch, m_duty[ch], m_cfg[ch]),
                  hf, m_cfg[ch][0] ? 0 : expect_hi);
        check_val($sformatf("%s_rev ch%0d duty%0h cfg%0d", tag, ch, m_duty[ch], m_cfg[ch]),
                  hr, m_cfg[ch][0] ? expect_hi : 0);
    endtask

    task automatic wait_rev0_rise(input int limit, output int k);
        logic prev;
        prev = pwm0[1];
        k = 0;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (!prev && pwm0[1]) return;
            prev = pwm0[1];
        end
        k = -1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] duties [3];
        int k, ntach;
        duties[0] = 8'h40; duties[1] = 8'hC0; duties[2] = 8'h80;

        reset = 1; sclk = 1; ss = 0; mosi = 0; tstn = 0; wdogdisn = 1;
        cl0 = 0; cl1 = 0; cl2 = 0; tach0 = 0; tach1 = 0; tach2 = 0;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        check_val("rst_motorena", motorena, 0);
        check_val("rst_pwm", {pwm2, pwm1, pwm0}, 0);
        check_val("rst_miso_undriven", miso, 1);

        spi_frame({1'b1, 4'hD, 3'b000}, 8'h00, 16, rd);
        check_val("hwcfg", rd, 8'h43);
        check_val("miso_idle_after", miso, 1);
        for (int a = 0; a < 16; a++) spi_rd_chk("rst_reg", 4'(a));

        // enable bits without the motor enable request
        spi_wr(4'hF, 8'h01); spi_rd_chk("wdctl", 4'hF); check_val("ena_off1", motorena, 0);
        spi_wr(4'hF, 8'h03); spi_rd_chk("wdctl", 4'hF); check_val("ena_off3", motorena, 0);
        spi_wr(4'hF, 8'h07); spi_rd_chk("wdctl", 4'hF); check_val("ena_off7", motorena, 0);

        // watchdog timeout, trip, clear and disable
        spi_wr(4'hE, 8'h10);
        spi_wr(4'hF, 8'h0F);
        check_val("wd_ena", motorena, 1);
        repeat (900) @(negedge clk);
        check_val("wd_before_trip", motorena, 1);
        repeat (350) @(negedge clk);
        check_val("wd_tripped", motorena, 0);
        m_trip = 1; m_mena = 0;
        spi_rd_chk("wd_trip_read", 4'hF);
        spi_wr(4'hF, 8'h80);
        spi_wr(4'hF, 8'h0F);
        spi_rd_chk("wd_rearm", 4'hF);
        check_val("wd_reenabled", motorena, 1);
        wdogdisn = 0;
        repeat (5000) @(negedge clk);
        check_val("wd_disabled", motorena, 1);

        // directed duties, forward drive, every channel
        for (int ch = 0; ch < 3; ch++) begin
            spi_wr(4'(ch * 4 + 2), 8'h00);
            for (int j = 0; j < 3; j++) begin
                spi_wr(4'(ch * 4), duties[j]);
                check_pwm("duty", ch);
            end
        end

        // randomized duty, direction, brake and channel enable
        for (int it = 0; it < 10; it++) begin
            int ch;
            logic [7:0] d;
            logic [1:0] c;
            logic [2:0] en;
            ch = $urandom_range(0, 2);
            d = 8'($urandom);
            c = 2'($urandom_range(0, 3));
            en = 3'($urandom_range(0, 7));
            if (it == 0) begin d = 8'hFF; c = 2'b00; en = 3'b111; end
            if (it == 1) begin d = 8'h00; en = 3'b111; end
            spi_wr(4'hF, {5'b00001, en});
            spi_wr(4'(ch * 4), d);
            spi_wr(4'(ch * 4 + 2), {6'd0, c});
            check_pwm("rnd", ch);
        end

        // cycle-by-cycle current limit on channel 0, reverse drive
        spi_wr(4'hF, 8'h0F);
        spi_wr(4'h2, 8'h01);
        spi_wr(4'h0, 8'hF0);
        wait_rev0_rise(600, k);
        check_val("cl_sync_found", k > 0, 1);
        repeat (50) @(negedge clk);
        cl0 = 1;
        repeat (3) @(negedge clk);
        cl0 = 0;
        repeat (47) @(negedge clk);
        check_val("cl_off_100", pwm0, 2'b00);
        repeat (100) @(negedge clk);
        check_val("cl_off_200", pwm0, 2'b00);
        wait_rev0_rise(600, k);
        check_val("cl_resume_at_wrap", k, 56);
        check_pwm("cl_after", 0);

        // status bit follows the comparator
        cl2 = 1;
        repeat (4) @(negedge clk);
        spi_rd_chk("stat_hi", 4'hB);
        cl2 = 0;
        repeat (4) @(negedge clk);
        spi_rd_chk("stat_lo", 4'hB);

        // tachometer counting
        for (int i = 0; i < 10; i++) begin
            tach1[0] = 1; repeat (4) @(negedge clk);
            tach1[0] = 0; repeat (4) @(negedge clk);
        end
        m_tach[1] += 8'd10;
        ntach = $urandom_range(1, 20);
        for (int i = 0; i < ntach; i++) begin
            tach0[0] = 1; repeat (3) @(negedge clk);
            tach0[0] = 0; repeat (5) @(negedge clk);
        end
        m_tach[0] += 8'(ntach);
        for (int i = 0; i < 5; i++) begin
            tach2[1] = 1; repeat (4) @(negedge clk);
            tach2[1] = 0; repeat (4) @(negedge clk);
        end
        spi_frame({1'b1, 4'h5, 3'b000}, 8'h00, 16, rd);
        check_val("tach1_ten", rd, 8'h0A);
        spi_rd_chk("tach", 4'h1);
        spi_rd_chk("tach", 4'h9);

        // aborted frame after 12 sclk leaves DUTY0 untouched
        spi_frame({1'b0, 4'h0, 3'b000}, ~m_duty[0], 12, rd);
        spi_rd_chk("abort", 4'h0);

        // reset mid-frame: the rest of that frame must be ignored
        spi_wr(4'h4, 8'h33);
        @(negedge clk);
        ss = 1;
        repeat (4) @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        model_reset();
        repeat (4) @(negedge clk);
        spi_frame({1'b0, 4'h4, 3'b000}, 8'h55, 16, rd);
        spi_rd_chk("reset_midframe", 4'h4);
        check_val("reset_motorena", motorena, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
